// File: rtl/if_stage_if.sv
// if_stage_if: req/gnt/rvalid instruction memory bus between the fetch stage and memory
interface if_stage_if;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  modport master (output instr_req_o, instr_addr_o, input instr_gnt_i, instr_rvalid_i, instr_rdata_i);
  modport slave (input instr_req_o, instr_addr_o, output instr_gnt_i, instr_rvalid_i, instr_rdata_i);
endinterface

// File: rtl/if_stage.sv
// if_stage: owns the PC, fetches over req/gnt/rvalid into a prefetch FIFO and drives the IF-ID register
module if_stage #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  if_stage_if.master  bus,
  input  logic        stall_from_ctrl_i,
  input  logic        refresh_pip_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  output logic [31:0] instr_rdata_id_o,
  output logic [31:0] instr_addr_id_o,
  output logic        instr_valid_id_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [31:0] aq [FIFO_DEPTH];
  logic [31:0] fd [FIFO_DEPTH];
  logic [31:0] fa [FIFO_DEPTH];
  logic [AW-1:0] aq_wr, aq_rd, fq_wr, fq_rd;
  logic [AW:0] out_q, cnt_q, disc_q, out_n, cnt_n, disc_n;
  logic [31:0] pc_q, redir_addr, tgt;
  logic req_q, redir_q, gnt, rv, keep, adv, pop, byp, push;
  assign bus.instr_req_o  = req_q;
  assign bus.instr_addr_o = pc_q;
  assign tgt = jump_addr_i & ~32'h3;
  always_comb begin
    gnt    = req_q & bus.instr_gnt_i;
    rv     = bus.instr_rvalid_i & (out_q != '0);
    keep   = rv & (disc_q == '0);
    adv    = ~jump_flag_i & ~refresh_pip_i & ~stall_from_ctrl_i;
    pop    = adv & (cnt_q != '0);
    byp    = adv & (cnt_q == '0) & keep;
    push   = keep & ~jump_flag_i & ~byp;
    out_n  = out_q + (AW+1)'(gnt) - (AW+1)'(rv);
    cnt_n  = jump_flag_i ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    // a beat granted after a pending redirect belongs to the old stream
    disc_n = jump_flag_i ? out_n : disc_q - (AW+1)'(rv & ~keep) + (AW+1)'(gnt & redir_q);
  end
  always_ff @(posedge clk_i) begin
    if (gnt) aq[aq_wr] <= pc_q;
    if (push) begin
      fd[fq_wr] <= bus.instr_rdata_i;
      fa[fq_wr] <= aq[aq_rd];
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q            <= 1'b0;
      pc_q             <= BOOT_ADDR;
      redir_q          <= 1'b0;
      redir_addr       <= '0;
      out_q            <= '0;
      cnt_q            <= '0;
      disc_q           <= '0;
      aq_wr            <= '0;
      aq_rd            <= '0;
      fq_wr            <= '0;
      fq_rd            <= '0;
      instr_rdata_id_o <= NOP_INSTR;
      instr_addr_id_o  <= '0;
      instr_valid_id_o <= 1'b0;
    end else begin
      // credit never shrinks while a request waits, so req stays up until gnt
      req_q  <= ({1'b0, out_n} + {1'b0, cnt_n}) < (AW+2)'(FIFO_DEPTH);
      out_q  <= out_n;
      cnt_q  <= cnt_n;
      disc_q <= disc_n;
      if (gnt) aq_wr <= aq_wr + 1'b1;
      if (rv) aq_rd <= aq_rd + 1'b1;
      if (jump_flag_i) begin
        fq_wr <= '0;
        fq_rd <= '0;
        if (req_q & ~bus.instr_gnt_i) begin
          redir_q    <= 1'b1;
          redir_addr <= tgt;
        end else begin
          redir_q <= 1'b0;
          pc_q    <= tgt;
        end
      end else begin
        if (gnt) begin
          pc_q    <= redir_q ? redir_addr : pc_q + 32'd4;
          redir_q <= 1'b0;
        end
        if (push) fq_wr <= fq_wr + 1'b1;
        if (pop) fq_rd <= fq_rd + 1'b1;
      end
      if (jump_flag_i | refresh_pip_i) begin
        instr_rdata_id_o <= NOP_INSTR;
        instr_addr_id_o  <= '0;
        instr_valid_id_o <= 1'b0;
      end else if (!stall_from_ctrl_i) begin
        instr_rdata_id_o <= pop ? fd[fq_rd] : byp ? bus.instr_rdata_i : NOP_INSTR;
        instr_addr_id_o  <= pop ? fa[fq_rd] : byp ? aq[aq_rd] : '0;
        instr_valid_id_o <= pop | byp;
      end
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench with a queued memory model driving the fetch bus
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct {logic [31:0] addr; logic stale;} beat_t;
  logic clk = 0, rst = 0, stall = 0, refresh = 0, jump = 0, gnt_en = 0, resp_en = 0;
  logic [31:0] jaddr = 0;
  logic [31:0] id_rdata, id_addr;
  logic id_valid;
  int checks = 0, errors = 0;
  beat_t mem_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_pc, redir_tgt, held_d, held_a;
  logic redir_pend, held_v;
  if_stage_if bus ();
  if_stage dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .stall_from_ctrl_i(stall), .refresh_pip_i(refresh), .jump_flag_i(jump), .jump_addr_i(jaddr),
    .instr_rdata_id_o(id_rdata), .instr_addr_id_o(id_addr), .instr_valid_id_o(id_valid)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask
  task automatic model_reset();
    mem_q.delete();
    exp_q.delete();
    exp_pc = 32'h0;
    redir_pend = 0;
    redir_tgt = 0;
    held_d = NOP;
    held_a = 0;
    held_v = 0;
  endtask
  task automatic step();
    logic p_req, p_gnt, p_rv, p_jump, p_ref, p_stall;
    logic [31:0] p_addr, p_tgt;
    logic [63:0] e;
    beat_t b;
    @(negedge clk);
    p_rv = resp_en && mem_q.size() > 0;
    bus.instr_gnt_i = gnt_en;
    bus.instr_rvalid_i = p_rv;
    bus.instr_rdata_i = p_rv ? ~mem_q[0].addr : 32'h0;
    #1;
    p_req = bus.instr_req_o;
    p_addr = bus.instr_addr_o;
    p_gnt = gnt_en;
    p_jump = jump;
    p_ref = refresh;
    p_stall = stall;
    p_tgt = jaddr & ~32'h3;
    if (p_req) check("fetch_addr", p_addr, exp_pc);
    @(posedge clk);
    #1;
    if (p_rv) begin
      b = mem_q.pop_front();
      if (!b.stale) exp_q.push_back({~b.addr, b.addr});
    end
    if (p_req && p_gnt) mem_q.push_back('{p_addr, redir_pend});
    if (p_jump) begin
      exp_q.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1;
      if (p_req && !p_gnt) begin
        redir_pend = 1;
        redir_tgt = p_tgt;
      end else begin
        redir_pend = 0;
        exp_pc = p_tgt;
      end
    end else if (p_req && p_gnt) begin
      exp_pc = redir_pend ? redir_tgt : exp_pc + 32'd4;
      redir_pend = 0;
    end
    if (p_jump || p_ref) begin
      held_d = NOP;
      held_v = 0;
    end else if (!p_stall) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        held_d = e[63:32];
        held_a = e[31:0];
        held_v = 1;
      end else begin
        held_d = NOP;
        held_v = 0;
      end
    end
    check("id_valid", id_valid, held_v);
    check("id_rdata", id_rdata, held_d);
    if (held_v) check("id_addr", id_addr, held_a);
  endtask
  task automatic check_reset_outputs(string tag);
    check({tag, "_req"}, bus.instr_req_o, 0);
    check({tag, "_addr"}, bus.instr_addr_o, 32'h0);
    check({tag, "_rdata"}, id_rdata, NOP);
    check({tag, "_iaddr"}, id_addr, 32'h0);
    check({tag, "_valid"}, id_valid, 0);
  endtask
  initial begin
    model_reset();
    bus.instr_gnt_i = 0;
    bus.instr_rvalid_i = 0;
    bus.instr_rdata_i = 0;
    #1 rst = 1;
    #1 check_reset_outputs("rst");
    repeat (2) step();
    rst = 0;
    gnt_en = 1;
    resp_en = 1;
    step();
    check("lat1_valid", id_valid, 0);
    step();
    check("lat2_valid", id_valid, 0);
    step();
    check("lat3_valid", id_valid, 1);
    check("lat3_addr", id_addr, 32'h0);
    repeat (8) step();
    gnt_en = 0;
    repeat (5) begin
      step();
      check("req_hold", bus.instr_req_o, 1);
    end
    gnt_en = 1;
    resp_en = 0;
    repeat (2) step();
    jump = 1;
    jaddr = 32'h0000_0102;
    step();
    jump = 0;
    check("jump_pc", bus.instr_addr_o, 32'h0000_0100);
    resp_en = 1;
    repeat (8) step();
    gnt_en = 0;
    resp_en = 0;
    step();
    jump = 1;
    jaddr = 32'h0000_0203;
    step();
    jump = 0;
    step();
    gnt_en = 1;
    step();
    check("redir_pc", bus.instr_addr_o, 32'h0000_0200);
    resp_en = 1;
    repeat (6) step();
    stall = 1;
    repeat (6) step();
    check("stall_credit", bus.instr_req_o, 0);
    refresh = 1;
    step();
    refresh = 0;
    stall = 0;
    repeat (10) step();
    jump = 1;
    jaddr = 32'hFFFF_FFF8;
    step();
    jump = 0;
    repeat (3) step();
    check("wrap_pc", bus.instr_addr_o, 32'h0000_0004);
    repeat (2) step();
    #2 rst = 1;
    #1 check_reset_outputs("async_rst");
    model_reset();
    bus.instr_rvalid_i = 0;
    repeat (2) step();
    rst = 0;
    repeat (6) step();
    repeat (400) begin
      gnt_en = ($urandom % 4) != 0;
      resp_en = ($urandom % 4) != 0;
      stall = ($urandom % 5) == 0;
      refresh = ($urandom % 10) == 0;
      jump = ($urandom % 15) == 0;
      jaddr = $urandom;
      step();
    end
    stall = 0;
    refresh = 0;
    jump = 0;
    gnt_en = 1;
    resp_en = 1;
    repeat (12) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
